// File: rtl/multi_resource_dot_engine.sv
// Dot-product engine: A/B vectors live in lane-banked RAMs (element i in bank i % LANES),
// so every lane reads its own bank each cycle; products feed a wrapping 64-bit accumulator.
module multi_resource_dot_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LANES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] index,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  input  logic [31:0]       n,
  output logic              done,
  output logic [63:0]       result
);
  localparam int LB     = $clog2(LANES);
  localparam int BANK_D = (2 ** ADDR_W) / LANES;
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [31:0] MAX_N = 32'(2 ** ADDR_W);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] ptr_reg;
  logic [CNT_W-1:0] n_reg;
  logic [LANES-1:0] lane_vld_reg;
  logic             prod_vld_reg;
  logic             done_reg;
  logic [63:0]      result_reg;

  logic                   idle_like;
  logic                   wr_en;
  logic                   start;
  logic [LANES-1:0]       lane_en;
  logic [LANES-1:0][63:0] prod_bus;
  logic [63:0]            prod_sum;

  // The RAMs only accept writes while no computation is in flight.
  assign idle_like = (state_reg == IDLE) || (state_reg == DONE);
  assign wr_en     = we && idle_like;
  assign start     = wr_en && (n != 32'd0) && (n <= MAX_N) &&
                     ({{(32-ADDR_W){1'b0}}, index} == (n - 32'd1));

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DATA_W-1:0] a_mem [BANK_D];
      logic [DATA_W-1:0] b_mem [BANK_D];
      logic [DATA_W-1:0] a_rd_reg;
      logic [DATA_W-1:0] b_rd_reg;
      logic [63:0]       prod_reg;
      logic [CNT_W-1:0]  lane_addr;

      // Lanes beyond n-1 (odd tail) neither read nor contribute.
      assign lane_addr   = ptr_reg + CNT_W'(gi);
      assign lane_en[gi] = (state_reg == RUN) && (lane_addr < n_reg);
      assign prod_bus[gi] = prod_reg;

      always_ff @(posedge clk) begin
        if (wr_en && (index[LB-1:0] == LB'(gi))) begin
          a_mem[index[ADDR_W-1:LB]] <= a_data;
          b_mem[index[ADDR_W-1:LB]] <= b_data;
        end
        if (lane_en[gi]) begin
          a_rd_reg <= a_mem[ptr_reg[ADDR_W-1:LB]];
          b_rd_reg <= b_mem[ptr_reg[ADDR_W-1:LB]];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prod_reg <= '0;
        end else if (lane_vld_reg[0]) begin
          prod_reg <= lane_vld_reg[gi] ? (64'(a_rd_reg) * 64'(b_rd_reg)) : 64'd0;
        end
      end
    end
  endgenerate

  always_comb begin
    prod_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_sum = prod_sum + prod_bus[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      n_reg        <= '0;
      lane_vld_reg <= '0;
      prod_vld_reg <= 1'b0;
      done_reg     <= 1'b0;
      result_reg   <= '0;
    end else begin
      lane_vld_reg <= lane_en;
      prod_vld_reg <= lane_vld_reg[0];
      if (prod_vld_reg) begin
        result_reg <= result_reg + prod_sum;
      end
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg  <= RUN;
            n_reg      <= n[CNT_W-1:0];
            ptr_reg    <= '0;
            done_reg   <= 1'b0;
            result_reg <= '0;
          end
        end
        RUN: begin
          ptr_reg <= ptr_reg + CNT_W'(LANES);
          if ((ptr_reg + CNT_W'(LANES)) >= n_reg) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          // Done once the read and product stages have both emptied.
          if (!lane_vld_reg[0] && !prod_vld_reg) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_multi_resource_dot_engine.sv
// Bench for multi_resource_dot_engine: directed cases plus randomized runs, checked every
// cycle against a plain-arithmetic model (memory arrays, countdown, summed products).
module tb_multi_resource_dot_engine;
  logic        clk;
  logic        rst;
  logic        we;
  logic [9:0]  index;
  logic [31:0] a_data;
  logic [31:0] b_data;
  logic [31:0] n;
  logic        done;
  logic [63:0] result;

  int vectors;
  int miscompares;

  multi_resource_dot_engine #(.DATA_W(32), .ADDR_W(10), .LANES(2)) dut (
    .clk(clk), .rst(rst), .we(we), .index(index), .a_data(a_data),
    .b_data(b_data), .n(n), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memories, a countdown to completion and the exact dot product.
  logic [31:0] ma [1024];
  logic [31:0] mb [1024];
  int unsigned m_cnt;
  logic [31:0] m_n;
  logic        m_done;
  logic [63:0] m_res;
  logic        m_res_known;

  function automatic logic [63:0] dot(input logic [31:0] cnt);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < int'(cnt); i++) s = s + 64'(ma[i]) * 64'(mb[i]);
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt       <= 0;
      m_done      <= 1'b0;
      m_res       <= '0;
      m_res_known <= 1'b1;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done      <= 1'b1;
        m_res       <= dot(m_n);
        m_res_known <= 1'b1;
      end
    end else if (we) begin
      ma[index] <= a_data;
      mb[index] <= b_data;
      if (n >= 32'd1 && n <= 32'd1024 && {22'd0, index} == n - 32'd1) begin
        m_n         <= n;
        m_cnt       <= (n + 32'd1) / 32'd2 + 32'd3;
        m_done      <= 1'b0;
        m_res_known <= 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      vectors++;
      if (done !== m_done) begin
        miscompares++;
        $display("FAIL cyc_done t=%0t: got %b expected %b", $time, done, m_done);
      end
      if (m_res_known) begin
        vectors++;
        if (result !== m_res) begin
          miscompares++;
          $display("FAIL cyc_result t=%0t: got %h expected %h", $time, result, m_res);
        end
      end
    end
  end

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int idx, input logic [31:0] a, input logic [31:0] b);
    we     = 1'b1;
    index  = 10'(idx);
    a_data = a;
    b_data = b;
    tick();
  endtask

  function automatic logic [9:0] pick_idx(input int forbid);
    logic [9:0] v;
    do v = 10'($urandom_range(0, 1023)); while (int'(v) == forbid);
    return v;
  endfunction

  function automatic logic [31:0] rnd();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFF;
    return $urandom;
  endfunction

  // Called right after the start edge; mode 0 = we low, 1 = we held high, 2 = random writes.
  task automatic wait_done(input int exp_edges, input int mode, input int forbid, input string name);
    int edges = 0;
    bit seen = 0;
    while (!seen && edges < 3000) begin
      if (mode == 0) we = 1'b0;
      else we = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      index  = pick_idx(forbid);
      a_data = rnd();
      b_data = rnd();
      tick();
      edges++;
      if (done) seen = 1;
    end
    we = 1'b0;
    check64({name, "_latency"}, 64'(edges), 64'(exp_edges));
    $display("run %s: n=%0d edges=%0d result=%h", name, m_n, edges, result);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nn;
    vectors = 0;
    miscompares = 0;
    rst = 1'b0; we = 1'b0; index = '0; a_data = '0; b_data = '0; n = 32'd0;
    #2 rst = 1'b1;
    #18 rst = 1'b0;
    tick();
    check64("reset_done", 64'(done), 64'd0);
    check64("reset_result", result, 64'd0);

    // Out-of-range n never starts; this also fills every RAM entry with defined data.
    n = 32'd2000;
    for (int k = 0; k < 1024; k++) write(k, rnd(), rnd());
    n = 32'd0;
    for (int k = 0; k < 1024; k++) write(k, rnd(), rnd());
    we = 1'b0;
    tick();
    check64("nostart_done", 64'(done), 64'd0);
    check64("nostart_result", result, 64'd0);

    // n=15 ramp with we held high throughout.
    n = 32'd15;
    for (int k = 0; k < 15; k++) write(k, 32'(10 * (k + 1)), 32'(k + 2));
    wait_done(11, 1, 14, "t1");
    check64("t1_result", result, 64'd13600);
    check64("t1_model", m_res, 64'd13600);
    we = 1'b1;
    for (int k = 0; k < 3; k++) begin
      index = pick_idx(14); a_data = rnd(); b_data = rnd();
      tick();
    end
    we = 1'b0;
    check64("t1_sticky_done", 64'(done), 64'd1);
    check64("t1_sticky_result", result, 64'd13600);

    // Single element.
    n = 32'd1;
    write(0, 32'd7, 32'd6);
    wait_done(4, 0, 0, "t2");
    check64("t2_result", result, 64'd42);
    check64("t2_model", m_res, 64'd42);

    // Maximal operands wrap the accumulator.
    n = 32'd4;
    for (int k = 0; k < 4; k++) write(k, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(5, 0, 3, "t3");
    check64("t3_result", result, 64'hFFFF_FFF8_0000_0004);
    check64("t3_model", m_res, 64'hFFFF_FFF8_0000_0004);

    // Reset three edges into a run clears outputs without waiting for a clock.
    n = 32'd20;
    for (int k = 0; k < 20; k++) write(k, rnd() | 32'd1, rnd() | 32'd1);
    we = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check64("t4_async_done", 64'(done), 64'd0);
    check64("t4_async_result", result, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 20; k++) write(k, rnd(), rnd());
    wait_done(13, 2, 19, "t4");
    check64("t4_result", result, m_res);

    // Rewrite after done: non-final index keeps done, final index restarts.
    n = 32'd2;
    write(0, 32'd1, 32'd1);
    we = 1'b0;
    check64("t5_done_kept", 64'(done), 64'd1);
    write(1, 32'd2, 32'd3);
    check64("t5_done_drop", 64'(done), 64'd0);
    wait_done(4, 0, 1, "t5a");
    check64("t5a_result", result, 64'd7);
    write(1, 32'd2, 32'd3);
    wait_done(4, 0, 1, "t5b");
    check64("t5b_result", result, 64'd7);

    // Randomized runs with assorted lengths and background write noise.
    for (int r = 0; r < 30; r++) begin
      nn = (r % 5 == 4) ? int'($urandom_range(1, 1024)) : int'($urandom_range(1, 40));
      n = 32'(nn);
      for (int e = 0; e < int'($urandom_range(0, 20)); e++) write(int'(pick_idx(nn - 1)), rnd(), rnd());
      write(nn - 1, rnd(), rnd());
      wait_done((nn + 1) / 2 + 3, 2, nn - 1, "rand");
      check64("rand_result", result, m_res);
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
